fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier.
- Successor to the team's combinational 8-bit FP multiplier. Adds:
  - generic exponent/fraction widths;
  - valid/ready handshakes on input and output;
  - four selectable rounding modes.
- Sits between the operand-issue logic and the result writeback/FIFO of the arithmetic datapath.

Parameters:
- EXP_W, 3, exponent field width (>=2).
- MAN_W, 4, stored fraction width, hidden bit excluded (>=1).
- Derived: W = 1+EXP_W+MAN_W, total word width (default 8).
- Derived: BIAS = 2^(EXP_W-1)-1 (default 3).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, operand pair valid.
- in_ready, out, 1, block can accept operands this cycle.
- a, in, W, operand A {sign, exp, frac}.
- b, in, W, operand B.
- rnd_mode, in, 2, 0=RNE, 1=RTZ, 2=RDN (toward -inf), 3=RUP (toward +inf).
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts result.
- result, out, W, product.
- flags, out, 5, {NV, DZ, OF, UF, NX}, bit 4 down to 0.

Behaviour:
- Reset (async, rst=1): all stage valids clear; out_valid=0, result=0, flags=0. in_ready=1 once rst deasserts.
- Reset mid-operation: in-flight ops are discarded, never emitted.
- Pipeline:
  - S1: unpack, classify, sign XOR, exponent sum, full (MAN_W+1)^2 mantissa product.
  - S2: normalise (1-bit shift), form guard/round/sticky, detect overflow/underflow.
  - S3: round, post-round renormalise, select special result, register outputs.
- Handshake:
  - advance = !out_valid || out_ready; all stages shift together when advance=1.
  - in_ready = advance, combinational.
  - An op is accepted on a cycle with in_valid && in_ready; rnd_mode is captured with it.
  - Latency is 3 cycles from acceptance to out_valid with out_ready held high. Throughput is 1/cycle.
- Stall: with out_ready=0 and out_valid=1, result/flags hold stable and no op is lost or duplicated.
- Operand classes:
  - exp=0 is zero. Subnormal inputs are treated as signed zero (DAZ); NX is not set for this.
  - exp=all-ones with frac=0 is Inf.
  - exp=all-ones with frac!=0 is NaN.
- Special results, highest priority first:
  - Any NaN operand, or Inf*0: canonical qNaN {0, all-ones, 1 followed by zeros}. NV=1 only for Inf*0 or a signalling NaN (frac MSB=0).
  - Inf*finite-nonzero or Inf*Inf: signed Inf, flags=0.
  - Zero*finite: signed zero, flags=0.
- Normal path:
  - Exponent is computed at EXP_W+2 bits signed: Ep = Ea+Eb-BIAS (+1 when product MSB set).
  - Rounding uses G/R/S per rnd_mode. RDN/RUP use the result sign.
  - A rounding carry increments the exponent and reshifts the mantissa.
  - NX = any of G/R/S nonzero.
- Overflow (post-round Ep >= 2^EXP_W-1):
  - OF=1, NX=1.
  - Result is Inf for RNE, or when the rounding direction is away from zero (RUP with positive, RDN with negative).
  - Otherwise result is the max finite {s, all-ones-1, all-ones}.
- Underflow (post-round Ep <= 0): flush to signed zero; UF=1, NX=1.
- DZ is always 0.

Decomposition:
- Package fp_mult_pkg holds:
  - rnd_mode_e enum;
  - flag bit index constants (FLG_NV..FLG_NX);
  - fp_class_e {ZERO, NORM, INF, QNAN, SNAN};
  - a parametrised classify function.
- One sub-module: fp_mult_round (S3 combinational rounding, overflow selection and special-result muxing), instantiated once.

Test Plan (defaults EXP_W=3, MAN_W=4, rnd_mode=RNE, out_ready=1 unless stated):
- a=0x38, b=0x38 (1.5*1.5) -> result 0x42, flags 5'b00000, out_valid exactly 3 cycles after acceptance.
- a=0x31, b=0x31 -> RNE: 0x32, flags 5'b00001; same operands with RUP -> 0x33, flags 5'b00001; with RTZ -> 0x32.
- a=0x6F, b=0x6F -> RNE: 0x70, flags 5'b00101; with RTZ -> 0x6F, flags 5'b00101; a=0xEF, b=0x6F with RDN -> 0xF0.
- a=0x70, b=0x00 -> 0x78, flags 5'b10000; a=0x10, b=0x10 -> 0x00, flags 5'b00011; a=0x90, b=0x10 -> 0x80, flags 5'b00011.
- Backpressure: issue 5 back-to-back ops with out_ready=0 -> in_ready drops after the pipeline fills, result holds stable. Then raise out_ready -> all 5 results emerge in order, none lost or duplicated.
- Assert rst for 1 cycle with 2 ops in flight -> out_valid=0, result=0, flags=0 immediately. Neither op is later emitted; the next op issued after reset completes in 3 cycles.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared types, flag indices and operand classification for fp_mult_pipe
package fp_mult_pkg;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RDN = 2'd2,
        RND_RUP = 2'd3
    } rnd_mode_e;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_QNAN,
        FP_SNAN
    } fp_class_e;

    typedef enum logic [1:0] {
        SPEC_NONE,
        SPEC_NAN,
        SPEC_INF,
        SPEC_ZERO
    } spec_e;

    localparam int MAX_EXP_W = 16;
    localparam int MAX_MAN_W = 64;

    // Fields arrive zero-extended to the maximum widths; expW/manW give the real ones.
    function automatic fp_class_e classify(input logic [MAX_EXP_W-1:0] expField,
                                           input logic [MAX_MAN_W-1:0] fracField,
                                           input int expW,
                                           input int manW);
        logic [MAX_EXP_W-1:0] expOnes;
        expOnes = (MAX_EXP_W'(1) << expW) - MAX_EXP_W'(1);
        if (expField == '0) return FP_ZERO;
        if (expField != expOnes) return FP_NORM;
        if (fracField == '0) return FP_INF;
        return fracField[6'(manW - 1)] ? FP_QNAN : FP_SNAN;
    endfunction

endpackage

// File: rtl/fp_mult_round.sv
// rtl/fp_mult_round.sv - final-stage rounding, overflow/underflow resolution and special-result select
module fp_mult_round
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic                 sign,
    input  logic [1:0]           spec,
    input  logic                 specNv,
    input  logic [EXP_W+1:0]     expIn,
    input  logic [MAN_W-1:0]     fracIn,
    input  logic                 guardBit,
    input  logic                 roundBit,
    input  logic                 stickyBit,
    input  logic [1:0]           rnd,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0]        EXP_ONES   = '1;
    localparam logic [EXP_W-1:0]        EXP_MAXFIN = EXP_ONES - EXP_W'(1);
    localparam logic signed [EW-1:0]    EXP_OVF    = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]    EXP_ZERO   = '0;
    localparam logic [W-1:0]            QNAN       = {1'b0, EXP_ONES, MAN_W'(1) << (MAN_W - 1)};

    logic signed [EW-1:0] expSigned;
    logic signed [EW-1:0] expRound;
    logic                 inexact;
    logic                 roundUp;
    logic                 ovfToInf;
    logic                 carry;
    logic [MAN_W+1:0]     mantRound;
    logic [MAN_W-1:0]     fracRound;

    always_comb begin
        expSigned = $signed(expIn);
        inexact   = guardBit | roundBit | stickyBit;
        roundUp   = 1'b0;
        ovfToInf  = 1'b0;
        case (rnd_mode_e'(rnd))
            RND_RNE: begin
                roundUp  = guardBit & (roundBit | stickyBit | fracIn[0]);
                ovfToInf = 1'b1;
            end
            RND_RDN: begin
                roundUp  = sign & inexact;
                ovfToInf = sign;
            end
            RND_RUP: begin
                roundUp  = !sign & inexact;
                ovfToInf = !sign;
            end
            default: begin
                roundUp  = 1'b0;
                ovfToInf = 1'b0;
            end
        endcase

        // A carry out of the hidden bit means the mantissa became 10.000..., i.e. 1.0 at exponent+1.
        mantRound = {2'b01, fracIn} + (MAN_W+2)'(roundUp);
        carry     = mantRound[MAN_W+1];
        fracRound = carry ? mantRound[MAN_W:1] : mantRound[MAN_W-1:0];
        expRound  = expSigned + EW'(carry);

        result = '0;
        flags  = '0;
        case (spec_e'(spec))
            SPEC_NAN: begin
                result         = QNAN;
                flags[FLG_NV]  = specNv;
            end
            SPEC_INF:  result = {sign, EXP_ONES, {MAN_W{1'b0}}};
            SPEC_ZERO: result = {sign, {(W-1){1'b0}}};
            default: begin
                if (expRound >= EXP_OVF) begin
                    result        = ovfToInf ? {sign, EXP_ONES, {MAN_W{1'b0}}}
                                             : {sign, EXP_MAXFIN, {MAN_W{1'b1}}};
                    flags[FLG_OF] = 1'b1;
                    flags[FLG_NX] = 1'b1;
                end else if (expRound <= EXP_ZERO) begin
                    result        = {sign, {(W-1){1'b0}}};
                    flags[FLG_UF] = 1'b1;
                    flags[FLG_NX] = 1'b1;
                end else begin
                    result        = {sign, expRound[EXP_W-1:0], fracRound};
                    flags[FLG_NX] = inexact;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage pipelined floating-point multiplier with valid/ready handshakes
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    // Selects the product bits below the round bit once normalised.
    localparam logic [PW-1:0] STICKY_MASK = (PW'(1) << (MAN_W - 1)) - PW'(1);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: unpack, classify, exponent sum, full mantissa product
    logic [EXP_W-1:0]     aExp, bExp;
    logic [MAN_W-1:0]     aFrac, bFrac;
    fp_class_e            aClass, bClass;
    logic signed [EW-1:0] expSum;
    logic [PW-1:0]        prod;

    assign aExp   = a[W-2 -: EXP_W];
    assign bExp   = b[W-2 -: EXP_W];
    assign aFrac  = a[MAN_W-1:0];
    assign bFrac  = b[MAN_W-1:0];
    assign aClass = classify(MAX_EXP_W'(aExp), MAX_MAN_W'(aFrac), EXP_W, MAN_W);
    assign bClass = classify(MAX_EXP_W'(bExp), MAX_MAN_W'(bFrac), EXP_W, MAN_W);
    assign expSum = EW'(aExp) + EW'(bExp) - EW'(BIAS);
    assign prod   = PW'({1'b1, aFrac}) * PW'({1'b1, bFrac});

    logic                 s1Valid, s1Sign;
    fp_class_e            s1AClass, s1BClass;
    logic signed [EW-1:0] s1ExpSum;
    logic [PW-1:0]        s1Prod;
    rnd_mode_e            s1Rnd;

    // Stage 2: special-case detection and 1-bit normalisation
    logic      aNan, bNan, aInf, bInf, aZero, bZero, infTimesZero, sigNan;
    spec_e     spec;
    logic      specNv;

    always_comb begin
        aNan         = (s1AClass == FP_QNAN) || (s1AClass == FP_SNAN);
        bNan         = (s1BClass == FP_QNAN) || (s1BClass == FP_SNAN);
        aInf         = (s1AClass == FP_INF);
        bInf         = (s1BClass == FP_INF);
        aZero        = (s1AClass == FP_ZERO);
        bZero        = (s1BClass == FP_ZERO);
        infTimesZero = (aInf && bZero) || (bInf && aZero);
        sigNan       = (s1AClass == FP_SNAN) || (s1BClass == FP_SNAN);
        spec         = SPEC_NONE;
        specNv       = 1'b0;
        if (aNan || bNan || infTimesZero) begin
            spec   = SPEC_NAN;
            specNv = infTimesZero || sigNan;
        end else if (aInf || bInf) begin
            spec = SPEC_INF;
        end else if (aZero || bZero) begin
            spec = SPEC_ZERO;
        end
    end

    logic                 prodMsb;
    logic [PW-1:0]        prodNorm;
    logic signed [EW-1:0] expNorm;
    logic [MAN_W-1:0]     fracNorm;
    logic                 guardBit, roundBit, stickyBit;

    assign prodMsb   = s1Prod[PW-1];
    assign prodNorm  = prodMsb ? s1Prod : (s1Prod << 1);
    assign expNorm   = s1ExpSum + EW'(prodMsb);
    assign fracNorm  = prodNorm[PW-2 -: MAN_W];
    assign guardBit  = prodNorm[PW-2-MAN_W];
    assign roundBit  = prodNorm[PW-3-MAN_W];
    assign stickyBit = |(prodNorm & STICKY_MASK);

    logic                 s2Valid, s2Sign, s2Nv, s2G, s2R, s2S;
    spec_e                s2Spec;
    logic signed [EW-1:0] s2Exp;
    logic [MAN_W-1:0]     s2Frac;
    rnd_mode_e            s2Rnd;

    // Stage 3: rounding and result selection, registered at the outputs
    logic [W-1:0] rndResult;
    logic [4:0]   rndFlags;

    fp_mult_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .sign     (s2Sign),
        .spec     (s2Spec),
        .specNv   (s2Nv),
        .expIn    (s2Exp),
        .fracIn   (s2Frac),
        .guardBit (s2G),
        .roundBit (s2R),
        .stickyBit(s2S),
        .rnd      (s2Rnd),
        .result   (rndResult),
        .flags    (rndFlags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid   <= 1'b0;
            s1Sign    <= 1'b0;
            s1AClass  <= FP_ZERO;
            s1BClass  <= FP_ZERO;
            s1ExpSum  <= '0;
            s1Prod    <= '0;
            s1Rnd     <= RND_RNE;
            s2Valid   <= 1'b0;
            s2Sign    <= 1'b0;
            s2Nv      <= 1'b0;
            s2G       <= 1'b0;
            s2R       <= 1'b0;
            s2S       <= 1'b0;
            s2Spec    <= SPEC_NONE;
            s2Exp     <= '0;
            s2Frac    <= '0;
            s2Rnd     <= RND_RNE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1Valid   <= in_valid;
            s1Sign    <= a[W-1] ^ b[W-1];
            s1AClass  <= aClass;
            s1BClass  <= bClass;
            s1ExpSum  <= expSum;
            s1Prod    <= prod;
            s1Rnd     <= rnd_mode_e'(rnd_mode);
            s2Valid   <= s1Valid;
            s2Sign    <= s1Sign;
            s2Nv      <= specNv;
            s2G       <= guardBit;
            s2R       <= roundBit;
            s2S       <= stickyBit;
            s2Spec    <= spec;
            s2Exp     <= expNorm;
            s2Frac    <= fracNorm;
            s2Rnd     <= s1Rnd;
            out_valid <= s2Valid;
            if (s2Valid) begin
                result <= rndResult;
                flags  <= rndFlags;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - randomized self-checking bench for fp_mult_pipe against a value-level model
module tb_fp_mult_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [1:0] rnd_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [4:0] flags;

    always #5 clk = ~clk;

    fp_mult_pipe #(.EXP_W(3), .MAN_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .rnd_mode (rnd_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    typedef struct {
        logic [12:0] expv;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct packed {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [1:0]  rm;
        logic [12:0] ve;
    } vec_t;

    // {flags, result} for hand-worked cases
    vec_t dirTab [15] = '{
        {8'h38, 8'h38, 2'd0, 13'h0042},
        {8'h31, 8'h31, 2'd0, 13'h0132},
        {8'h31, 8'h31, 2'd3, 13'h0133},
        {8'h31, 8'h31, 2'd1, 13'h0132},
        {8'h6F, 8'h6F, 2'd0, 13'h0570},
        {8'h6F, 8'h6F, 2'd1, 13'h056F},
        {8'hEF, 8'h6F, 2'd2, 13'h05F0},
        {8'h70, 8'h00, 2'd0, 13'h1078},
        {8'h10, 8'h10, 2'd0, 13'h0300},
        {8'h90, 8'h10, 2'd0, 13'h0380},
        {8'h71, 8'h38, 2'd0, 13'h1078},
        {8'h79, 8'h38, 2'd0, 13'h0078},
        {8'hF0, 8'h70, 2'd0, 13'h00F0},
        {8'h80, 8'h38, 2'd0, 13'h0080},
        {8'h31, 8'h38, 2'd0, 13'h013A}
    };

    exp_t sbQ [$];
    int   nVec  = 0;
    int   nChk  = 0;
    int   nFail = 0;
    int   nPop  = 0;
    int   cyc   = 0;
    bit   latOn = 1'b1;
    bit   done  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        nChk++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Exact integer product of the two significands, rounded by remainder comparison.
    function automatic logic [12:0] refModel(input logic [7:0] x, input logic [7:0] y,
                                             input logic [1:0] rm);
        int   ex, ey, fx, fy, p, len, sh, kept, rem, half, e;
        logic sgn, nx, up, xNan, yNan, xInf, yInf, xZero, yZero, invalid;
        sgn     = x[7] ^ y[7];
        ex      = int'(x[6:4]);
        ey      = int'(y[6:4]);
        fx      = int'(x[3:0]);
        fy      = int'(y[3:0]);
        xNan    = (ex == 7) && (fx != 0);
        yNan    = (ey == 7) && (fy != 0);
        xInf    = (ex == 7) && (fx == 0);
        yInf    = (ey == 7) && (fy == 0);
        xZero   = (ex == 0);
        yZero   = (ey == 0);
        invalid = (xInf && yZero) || (yInf && xZero);
        if (xNan || yNan || invalid)
            return {invalid || (xNan && fx < 8) || (yNan && fy < 8), 4'b0000, 8'h78};
        if (xInf || yInf) return {5'b00000, sgn, 7'h70};
        if (xZero || yZero) return {5'b00000, sgn, 7'h00};
        p    = (16 + fx) * (16 + fy);
        len  = (p >= 512) ? 10 : 9;
        sh   = len - 5;
        kept = p >> sh;
        rem  = p - (kept << sh);
        half = 1 << (sh - 1);
        e    = ex + ey - 3 + (len - 9);
        nx   = (rem != 0);
        case (rm)
            2'd0:    up = (rem > half) || (rem == half && (kept % 2) == 1);
            2'd1:    up = 1'b0;
            2'd2:    up = sgn && nx;
            default: up = !sgn && nx;
        endcase
        kept = kept + int'(up);
        if (kept == 32) begin
            kept = 16;
            e    = e + 1;
        end
        if (e >= 7) begin
            if (rm == 2'd0 || (rm == 2'd3 && !sgn) || (rm == 2'd2 && sgn))
                return {5'b00101, sgn, 7'h70};
            return {5'b00101, sgn, 7'h6F};
        end
        if (e <= 0) return {5'b00011, sgn, 7'h00};
        return {4'b0000, nx, sgn, e[2:0], kept[3:0]};
    endfunction

    always @(negedge clk) begin
        exp_t ent;
        if (rst) begin
            sbQ.delete();
        end else begin
            if (out_valid) begin
                if (sbQ.size() == 0) begin
                    chk("spurious_out_valid", 16'(out_valid), 16'(0));
                end else begin
                    chk("product", 16'({flags, result}), 16'(sbQ[0].expv));
                    if (sbQ[0].lat) begin
                        chk("latency", 16'(cyc - sbQ[0].acc), 16'(3));
                        sbQ[0].lat = 1'b0;
                    end
                    if (out_ready) begin
                        void'(sbQ.pop_front());
                        nPop++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                ent.expv = refModel(a, b, rnd_mode);
                ent.acc  = cyc;
                ent.lat  = latOn;
                sbQ.push_back(ent);
                nVec++;
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] rm);
        int waitCyc;
        a        = x;
        b        = y;
        rnd_mode = rm;
        in_valid = 1'b1;
        waitCyc  = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waitCyc++;
            if (waitCyc > 100) begin
                chk("accept_timeout", 16'(waitCyc), 16'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sbQ.size() != 0) chk("drain_timeout", 16'(sbQ.size()), 16'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        rnd_mode  = 2'd0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 16'(out_valid), 16'(0));
        chk("reset_result", 16'(result), 16'(0));
        chk("reset_flags", 16'(flags), 16'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("in_ready_after_reset", 16'(in_ready), 16'(1));

        // hand-worked cases: pin the model, then run them back to back
        latOn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk("model_pin", 16'(refModel(dirTab[i].va, dirTab[i].vb, dirTab[i].rm)), 16'(dirTab[i].ve));
            issue(dirTab[i].va, dirTab[i].vb, dirTab[i].rm);
        end
        drain();

        // backpressure: five ops against a stalled consumer
        latOn     = 1'b0;
        out_ready = 1'b0;
        p0        = nPop;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    issue({1'($urandom), 3'($urandom_range(1, 6)), 4'($urandom)},
                          {1'($urandom), 3'($urandom_range(1, 6)), 4'($urandom)},
                          2'($urandom_range(0, 3)));
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("stall_in_ready", 16'(in_ready), 16'(0));
                chk("stall_out_valid", 16'(out_valid), 16'(1));
                out_ready = 1'b1;
            end
        join
        drain();
        chk("backpressure_pops", 16'(nPop - p0), 16'(5));

        // random operands, modes and consumer readiness
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    issue(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // reset with two ops in flight
        latOn = 1'b1;
        issue(8'h38, 8'h38, 2'd0);
        issue(8'h31, 8'h31, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 16'(out_valid), 16'(0));
        chk("midrst_result", 16'(result), 16'(0));
        chk("midrst_flags", 16'(flags), 16'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", 16'(in_ready), 16'(1));
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_emit", 16'(out_valid), 16'(0));
        issue(8'h31, 8'h31, 2'd3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        nFail++;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $fatal(1);
    end

endmodule
